mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//   Memory-access stage directly downstream of the ALU (alu1). Takes alu_result as the
//   effective address for ALU_LB..ALU_SW (codes from define.vh), drives a single-port
//   req/ack data-memory bus, and aligns and extends load data. Non-memory results pass
//   through to writeback with 1-cycle latency. At most one memory transaction in flight.
// PARAMETERS
//   TIMEOUT_CYCLES  16  cycles mem_req may wait for mem_ack before bus error; 1..255
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   reset, asynchronous, active-low
//   ex_valid     in   1   execute-stage result valid
//   ex_ready     out  1   stage accepts ex_* this cycle
//   ex_alucode   in   6   alucode the ALU executed (define.vh encoding)
//   ex_result    in   32  alu_result: effective address or pass-through value
//   ex_wdata     in   32  store data (rs2), low bits significant
//   ex_rd        in   5   destination register
//   ex_rd_we     in   1   instruction writes rd
//   mem_req      out  1   bus request
//   mem_we       out  1   1 = store
//   mem_addr     out  32  word-aligned address ({addr[31:2],2'b00})
//   mem_be       out  4   byte enables, bit i = byte lane i
//   mem_wdata    out  32  lane-replicated store data
//   mem_ack      in   1   transaction complete; mem_rdata valid this cycle for loads
//   mem_rdata    in   32  load data
//   wb_valid     out  1   writeback entry valid, single-cycle pulse
//   wb_we        out  1   write wb_data to wb_rd
//   wb_rd        out  5   destination register
//   wb_data      out  32  writeback value
//   misalign     out  1   with wb_valid: misaligned access, no bus cycle issued
//   bus_err      out  1   with wb_valid: mem_ack timeout
// BEHAVIOUR
//   Reset: every output 0 except ex_ready=1. State IDLE. Timeout counter 0. All outputs registered.
//   IDLE, ex_ready=1, handshake ex_valid&ex_ready:
//     non-mem code -> next cycle wb_valid=1, wb_data=ex_result, wb_we=ex_rd_we,
//       wb_rd=ex_rd. Stay IDLE, so throughput is 1 per cycle.
//     mem code, misaligned -> next cycle wb_valid=1, misalign=1, wb_we=0. No mem_req.
//       Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
//       Byte ops never misalign.
//     mem code, aligned -> latch op/addr/data/rd. Next cycle mem_req=1 and go to BUSY.
//   BUSY: ex_ready=0. mem_req/we/addr/be/wdata held stable until mem_ack is sampled high.
//     mem_ack in the first mem_req cycle is legal. Minimum latency: accept at cycle N,
//       mem_req at N+1, wb_valid at N+2.
//     On ack: mem_req=0 next cycle. wb_valid=1 same cycle, then IDLE.
//       Loads: wb_we=ex_rd_we. Stores: wb_we=0.
//     Timeout: counter counts mem_req-high cycles without ack. When it reaches
//       TIMEOUT_CYCLES: drop mem_req, wb_valid=1, bus_err=1, wb_we=0, then IDLE.
//     Ack and timeout in the same cycle: ack wins.
//   Stores: SB be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
//     SH be=addr[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}}.
//     SW be=4'b1111, wdata=ex_wdata.
//   Loads: mem_be as for the same-width store.
//     Lane select: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16].
//     LB/LH sign-extend. LBU/LHU zero-extend. LW takes the full word.
//   mem_ack while not BUSY: ignored.
//   misalign and bus_err are 0 whenever wb_valid=0.
//   Reset mid-transaction: outputs drop asynchronously. Transaction abandoned, no writeback.
//     Memory side must tolerate an abandoned request.
// TESTING
//   ALU_ADD, ex_result=0x59, rd=5, rd_we=1 -> next cycle wb_valid, wb_data=0x59, wb_we=1,
//     mem_req never high. Back-to-back adds give wb_valid every cycle.
//   ALU_SB, addr=0x1003, wdata=0xA5, ack 3 cycles after req -> mem_addr=0x1000,
//     be=4'b1000, wdata=0xA5A5A5A5, we=1, held 3 cycles; wb_valid with wb_we=0; ex_ready low meanwhile.
//   mem_rdata=0x12F03456, ack in first req cycle:
//     LB  0x2002 -> 0xFFFFFFF0
//     LBU 0x2002 -> 0x000000F0
//     LH  0x2002 -> 0x000012F0
//     LW  0x2000 -> 0x12F03456
//     each with wb_valid at N+2.
//   LW 0x2002 and SH 0x2001 -> misalign=1, wb_we=0, no mem_req; ALU_LB 0x2003 aligned -> bus cycle.
//   ALU_LW with no ack, TIMEOUT_CYCLES=16 -> mem_req high exactly 16 cycles, then wb_valid+bus_err.
//     Repeat with ack on cycle 16 -> normal load, bus_err=0.
//   rst_n low during BUSY -> mem_req=0 and ex_ready=1 immediately; after release, next
//     ALU_SW completes normally; late ack from the old transaction is ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage: turns ALU load/store results into a single req/ack data-memory
// transaction and aligns/extends load data; all other results pass through in one cycle.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [5:0]  ex_alucode,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    input  logic        ex_rd_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign,
    output logic        bus_err
);

    // Memory alucodes, matching the ALU's define.vh encoding.
    localparam logic [5:0] ALU_LB  = 6'd9;
    localparam logic [5:0] ALU_LH  = 6'd10;
    localparam logic [5:0] ALU_LW  = 6'd11;
    localparam logic [5:0] ALU_LBU = 6'd12;
    localparam logic [5:0] ALU_LHU = 6'd13;
    localparam logic [5:0] ALU_SB  = 6'd14;
    localparam logic [5:0] ALU_SH  = 6'd15;
    localparam logic [5:0] ALU_SW  = 6'd16;

    localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic [5:0]  op, op_next;
    logic [1:0]  lane, lane_next;
    logic [4:0]  rd_l, rd_l_next;
    logic        rd_we_l, rd_we_l_next;

    logic        ex_ready_next, mem_req_next, mem_we_next;
    logic [31:0] mem_addr_next, mem_wdata_next;
    logic [3:0]  mem_be_next;
    logic        wb_valid_next, wb_we_next, misalign_next, bus_err_next;
    logic [4:0]  wb_rd_next;
    logic [31:0] wb_data_next;

    logic        is_mem, is_store, is_misaligned;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Decode of the incoming execute result: lane enables, replicated data, alignment.
    always_comb begin
        is_mem        = (ex_alucode >= ALU_LB) && (ex_alucode <= ALU_SW);
        is_store      = (ex_alucode == ALU_SB) || (ex_alucode == ALU_SH) || (ex_alucode == ALU_SW);
        is_misaligned = 1'b0;
        acc_be        = 4'b1111;
        acc_wdata     = ex_wdata;
        case (ex_alucode)
            ALU_LB, ALU_LBU, ALU_SB: begin
                acc_be    = 4'b0001 << ex_result[1:0];
                acc_wdata = {4{ex_wdata[7:0]}};
            end
            ALU_LH, ALU_LHU, ALU_SH: begin
                acc_be        = ex_result[1] ? 4'b1100 : 4'b0011;
                acc_wdata     = {2{ex_wdata[15:0]}};
                is_misaligned = ex_result[0];
            end
            ALU_LW, ALU_SW: begin
                is_misaligned = (ex_result[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    // Lane selection and extension of returned load data, driven by the latched op.
    always_comb begin
        ld_byte = mem_rdata[{lane, 3'b000} +: 8];
        ld_half = mem_rdata[{lane[1], 4'b0000} +: 16];
        case (op)
            ALU_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            ALU_LBU: ld_data = {24'd0, ld_byte};
            ALU_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
            ALU_LHU: ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        op_next        = op;
        lane_next      = lane;
        rd_l_next      = rd_l;
        rd_we_l_next   = rd_we_l;
        ex_ready_next  = ex_ready;
        mem_req_next   = mem_req;
        mem_we_next    = mem_we;
        mem_addr_next  = mem_addr;
        mem_be_next    = mem_be;
        mem_wdata_next = mem_wdata;
        wb_valid_next  = 1'b0;
        wb_we_next     = 1'b0;
        wb_rd_next     = wb_rd;
        wb_data_next   = wb_data;
        misalign_next  = 1'b0;
        bus_err_next   = 1'b0;

        case (state)
            IDLE: begin
                ex_ready_next = 1'b1;
                if (ex_valid && ex_ready) begin
                    wb_rd_next = ex_rd;
                    if (!is_mem) begin
                        wb_valid_next = 1'b1;
                        wb_we_next    = ex_rd_we;
                        wb_data_next  = ex_result;
                    end else if (is_misaligned) begin
                        wb_valid_next = 1'b1;
                        misalign_next = 1'b1;
                        wb_data_next  = 32'd0;
                    end else begin
                        state_next     = BUSY;
                        ex_ready_next  = 1'b0;
                        cnt_next       = 8'd0;
                        op_next        = ex_alucode;
                        lane_next      = ex_result[1:0];
                        rd_l_next      = ex_rd;
                        rd_we_l_next   = ex_rd_we;
                        mem_req_next   = 1'b1;
                        mem_we_next    = is_store;
                        mem_addr_next  = {ex_result[31:2], 2'b00};
                        mem_be_next    = acc_be;
                        mem_wdata_next = is_store ? acc_wdata : 32'd0;
                    end
                end
            end
            BUSY: begin
                ex_ready_next = 1'b0;
                // Ack is checked first so it wins over a timeout in the same cycle.
                if (mem_ack || (cnt + 8'd1 == TIMEOUT)) begin
                    state_next     = IDLE;
                    ex_ready_next  = 1'b1;
                    cnt_next       = 8'd0;
                    mem_req_next   = 1'b0;
                    mem_we_next    = 1'b0;
                    mem_addr_next  = 32'd0;
                    mem_be_next    = 4'd0;
                    mem_wdata_next = 32'd0;
                    wb_valid_next  = 1'b1;
                    wb_rd_next     = rd_l;
                    if (mem_ack) begin
                        wb_we_next   = rd_we_l && !mem_we;
                        wb_data_next = mem_we ? 32'd0 : ld_data;
                    end else begin
                        bus_err_next = 1'b1;
                        wb_data_next = 32'd0;
                    end
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            op        <= 6'd0;
            lane      <= 2'd0;
            rd_l      <= 5'd0;
            rd_we_l   <= 1'b0;
            ex_ready  <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= 32'd0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            op        <= op_next;
            lane      <= lane_next;
            rd_l      <= rd_l_next;
            rd_we_l   <= rd_we_l_next;
            ex_ready  <= ex_ready_next;
            mem_req   <= mem_req_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_be    <= mem_be_next;
            mem_wdata <= mem_wdata_next;
            wb_valid  <= wb_valid_next;
            wb_we     <= wb_we_next;
            wb_rd     <= wb_rd_next;
            wb_data   <= wb_data_next;
            misalign  <= misalign_next;
            bus_err   <= bus_err_next;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: bus-side checks inline, writeback entries
// checked against an expected queue by a monitor.
module tb_mem_access_stage;

    localparam logic [5:0] ALU_LB  = 6'd9;
    localparam logic [5:0] ALU_LH  = 6'd10;
    localparam logic [5:0] ALU_LW  = 6'd11;
    localparam logic [5:0] ALU_LBU = 6'd12;
    localparam logic [5:0] ALU_LHU = 6'd13;
    localparam logic [5:0] ALU_SB  = 6'd14;
    localparam logic [5:0] ALU_SH  = 6'd15;
    localparam logic [5:0] ALU_SW  = 6'd16;
    localparam logic [5:0] ALU_ADD = 6'd17;

    logic        clk, rst_n;
    logic        ex_valid, ex_ready, ex_rd_we;
    logic [5:0]  ex_alucode;
    logic [31:0] ex_result, ex_wdata;
    logic [4:0]  ex_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_valid, wb_we, misalign, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_cmp = 0;
    int n_err = 0;
    // {misalign, bus_err, we, rd[4:0], data[31:0]}
    logic [39:0] exp_q[$];

    mem_access_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alucode(ex_alucode),
        .ex_result(ex_result), .ex_wdata(ex_wdata), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign(misalign), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic mis, input logic err, input logic we,
                        input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back({mis, err, we, rd, data});
    endtask

    task automatic drive(input logic [5:0] code, input logic [31:0] res,
                         input logic [31:0] wd, input logic [4:0] rd, input logic rd_we);
        ex_valid   = 1'b1;
        ex_alucode = code;
        ex_result  = res;
        ex_wdata   = wd;
        ex_rd      = rd;
        ex_rd_we   = rd_we;
    endtask

    // Writeback monitor: pops one expected entry per wb_valid pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    check("wb_unexpected", 40'd1, 40'd0);
                end else begin
                    logic [39:0] e;
                    e = exp_q.pop_front();
                    check("wb_flags_we_rd", {32'd0, misalign, bus_err, wb_we, wb_rd}, {32'd0, e[39:32]});
                    if (e[37]) check("wb_data", {8'd0, wb_data}, {8'd0, e[31:0]});
                end
            end else begin
                check("flags_without_valid", {38'd0, misalign, bus_err}, 40'd0);
            end
        end
    end

    // Load with ack in the first request cycle; also checks the N+2 writeback timing.
    task automatic load_fast(input logic [5:0] code, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [3:0] be,
                             input logic [31:0] exp, input logic [4:0] rd);
        push(1'b0, 1'b0, 1'b1, rd, exp);
        drive(code, addr, 32'd0, rd, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        check("ld_req", {38'd0, mem_req, mem_we}, {38'd0, 2'b10});
        check("ld_addr", {8'd0, mem_addr}, {8'd0, addr[31:2], 2'b00});
        check("ld_be", {36'd0, mem_be}, {36'd0, be});
        check("ld_wb_not_yet", {39'd0, wb_valid}, 40'd0);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ack = 1'b0;
        check("ld_done", {37'd0, wb_valid, mem_req, ex_ready}, {37'd0, 3'b101});
    endtask

    task automatic store_ack(input logic [5:0] code, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] be,
                             input logic [31:0] exp_wd, input int wait_cycles);
        push(1'b0, 1'b0, 1'b0, 5'd4, 32'd0);
        drive(code, addr, wd, 5'd4, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        for (int i = 0; i < wait_cycles; i++) begin
            check("st_req_we_ready", {37'd0, mem_req, mem_we, ex_ready}, {37'd0, 3'b110});
            check("st_addr", {8'd0, mem_addr}, {8'd0, addr[31:2], 2'b00});
            check("st_be", {36'd0, mem_be}, {36'd0, be});
            check("st_wdata", {8'd0, mem_wdata}, {8'd0, exp_wd});
            if (i == wait_cycles - 1) mem_ack = 1'b1;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check("st_done", {37'd0, wb_valid, mem_req, ex_ready}, {37'd0, 3'b101});
    endtask

    task automatic misaligned(input logic [5:0] code, input logic [31:0] addr);
        push(1'b1, 1'b0, 1'b0, 5'd3, 32'd0);
        drive(code, addr, 32'hFFFF_FFFF, 5'd3, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        check("mis_out", {37'd0, wb_valid, mem_req, ex_ready}, {37'd0, 3'b101});
        @(negedge clk);
        check("mis_no_req", {39'd0, mem_req}, 40'd0);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_alucode = 6'd0; ex_result = 32'd0;
        ex_wdata = 32'd0; ex_rd = 5'd0; ex_rd_we = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_ready_req_wb", {36'd0, ex_ready, mem_req, wb_valid, wb_we}, {36'd0, 4'b1000});
        check("rst_bus", {3'd0, mem_we, mem_be, mem_addr}, 40'd0);
        check("rst_wb", {3'd0, misalign, bus_err, wb_rd, wb_data[29:0]}, 40'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Pass-through, single and back-to-back.
        push(1'b0, 1'b0, 1'b1, 5'd5, 32'h59);
        drive(ALU_ADD, 32'h59, 32'd0, 5'd5, 1'b1);
        @(negedge clk);
        check("add_wb_next_cycle", {38'd0, wb_valid, mem_req}, {38'd0, 2'b10});
        for (int i = 0; i < 4; i++) begin
            logic [31:0] v;
            v = $urandom_range(0, 32'hFFFF);
            push(1'b0, 1'b0, i[0], 5'(i + 10), v);
            drive(ALU_ADD, v, 32'd0, 5'(i + 10), i[0]);
            @(negedge clk);
            check("add_b2b", {37'd0, wb_valid, mem_req, ex_ready}, {37'd0, 3'b101});
        end
        ex_valid = 1'b0;
        @(negedge clk);
        check("add_drained", {39'd0, wb_valid}, 40'd0);

        // Byte store held for three request cycles.
        store_ack(ALU_SB, 32'h1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 3);

        // Loads with ack in the first request cycle.
        load_fast(ALU_LB,  32'h2002, 32'h12F0_3456, 4'b0100, 32'hFFFF_FFF0, 5'd6);
        load_fast(ALU_LBU, 32'h2002, 32'h12F0_3456, 4'b0100, 32'h0000_00F0, 5'd7);
        load_fast(ALU_LH,  32'h2002, 32'h12F0_3456, 4'b1100, 32'h0000_12F0, 5'd8);
        load_fast(ALU_LW,  32'h2000, 32'h12F0_3456, 4'b1111, 32'h12F0_3456, 5'd9);
        load_fast(ALU_LH,  32'h2000, 32'h0000_8001, 4'b0011, 32'hFFFF_8001, 5'd10);
        load_fast(ALU_LHU, 32'h2000, 32'h0000_8001, 4'b0011, 32'h0000_8001, 5'd11);
        load_fast(ALU_LBU, 32'h2001, 32'h12F0_3456, 4'b0010, 32'h0000_0034, 5'd12);

        // Misalignment, and the byte load at an odd address that is not misaligned.
        misaligned(ALU_LW, 32'h2002);
        misaligned(ALU_SH, 32'h2001);
        misaligned(ALU_LHU, 32'h2003);
        misaligned(ALU_SW, 32'h2001);
        load_fast(ALU_LB, 32'h2003, 32'h92F0_3456, 4'b1000, 32'hFFFF_FF92, 5'd13);

        store_ack(ALU_SH, 32'h2002, 32'hBEEF_1234, 4'b1100, 32'h1234_1234, 1);
        store_ack(ALU_SW, 32'h2004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 2);

        // Timeout: exactly 16 request cycles, then bus error.
        push(1'b0, 1'b1, 1'b0, 5'd9, 32'd0);
        drive(ALU_LW, 32'h3000, 32'd0, 5'd9, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("to_req_held", {39'd0, mem_req}, 40'd1);
            @(negedge clk);
        end
        check("to_end", {37'd0, wb_valid, mem_req, ex_ready}, {37'd0, 3'b101});

        // Ack on the 16th request cycle beats the timeout.
        push(1'b0, 1'b0, 1'b1, 5'd9, 32'h0BAD_CAFE);
        drive(ALU_LW, 32'h3000, 32'd0, 5'd9, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("ack16_req_held", {39'd0, mem_req}, 40'd1);
            if (i == 15) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h0BAD_CAFE;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check("ack16_end", {37'd0, wb_valid, mem_req, ex_ready}, {37'd0, 3'b101});

        // Reset in the middle of a transaction.
        drive(ALU_SW, 32'h4000, 32'h1111_2222, 5'd1, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0;
        check("rst_mid_req", {39'd0, mem_req}, 40'd1);
        #1 rst_n = 1'b0;
        #1 check("rst_mid_async", {38'd0, mem_req, ex_ready}, {38'd0, 2'b01});
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_ignored", {37'd0, wb_valid, mem_req, ex_ready}, {37'd0, 3'b001});
        store_ack(ALU_SW, 32'h4008, 32'h3333_4444, 4'b1111, 32'h3333_4444, 2);

        repeat (3) @(negedge clk);
        check("queue_empty", 40'(exp_q.size()), 40'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
